// File: rtl/pwm_capture.sv
// PWM period / high-time capture with a two-flop input synchroniser,
// a constant-level timeout and a quarter-step LED brightness bar.
module pwm_capture #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_pwm,
    output logic [CNT_WIDTH-1:0] o_high,
    output logic [CNT_WIDTH-1:0] o_period,
    output logic                 o_valid,
    output logic                 o_stuck,
    output logic                 o_level,
    output logic [3:0]           o_led
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    state_e               state_q;
    logic                 s1_q, s2_q, s3_q;
    logic [CNT_WIDTH-1:0] per_q, hi_q, idle_q;
    logic [CNT_WIDTH-1:0] high_q, period_q;
    logic                 valid_q, stuck_q;
    logic                 rise;

    assign rise = s2_q & ~s3_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            per_q    <= '0;
            hi_q     <= '0;
            idle_q   <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            s1_q    <= i_pwm;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_q <= StMeasure;
                        per_q   <= CntOne;
                        hi_q    <= CntOne;
                        idle_q  <= '0;
                        stuck_q <= 1'b0;
                    end else begin
                        // Idle counter saturates; stuck fires on the last counted cycle.
                        if (idle_q != CntMax) idle_q <= idle_q + 1'b1;
                        if (idle_q == CntMax - 1'b1) stuck_q <= 1'b1;
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        high_q   <= hi_q;
                        period_q <= per_q;
                        valid_q  <= 1'b1;
                        per_q    <= CntOne;
                        hi_q     <= CntOne;
                    end else if (per_q == CntMax) begin
                        state_q <= StIdle;
                        stuck_q <= 1'b1;
                        per_q   <= '0;
                        hi_q    <= '0;
                        idle_q  <= '0;
                    end else begin
                        per_q <= per_q + 1'b1;
                        if (s2_q) hi_q <= hi_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Thresholds (2k+1)*period against 8*high, widened so nothing overflows.
    logic [CNT_WIDTH+3:0] hi8, p1, p3, p5, p7;

    always_comb begin
        hi8 = {1'b0, high_q, 3'b000};
        p1  = {4'b0000, period_q};
        p3  = (p1 << 1) + p1;
        p5  = (p1 << 2) + p1;
        p7  = (p1 << 3) - p1;
        o_led = 4'b0000;
        if (stuck_q) begin
            o_led = {4{s2_q}};
        end else if (period_q != '0) begin
            o_led[0] = (hi8 >= p1);
            o_led[1] = (hi8 >= p3);
            o_led[2] = (hi8 >= p5);
            o_led[3] = (hi8 >= p7);
        end
    end

    assign o_high   = high_q;
    assign o_period = period_q;
    assign o_valid  = valid_q;
    assign o_stuck  = stuck_q;
    assign o_level  = s2_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench: stimulus pushes expected captures (with arrival cycle),
// a negedge monitor pops and compares. A second 8-bit instance covers timeout.
module tb_pwm_capture;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm = 1'b0;

    logic [15:0] high16, period16;
    logic        valid16, stuck16, level16;
    logic [3:0]  led16;
    logic [7:0]  high8, period8;
    logic        valid8, stuck8, level8;
    logic [3:0]  led8;

    pwm_capture #(.CNT_WIDTH(16)) dut16 (
        .i_clk(clk), .i_reset_n(rst_n), .i_pwm(pwm),
        .o_high(high16), .o_period(period16), .o_valid(valid16),
        .o_stuck(stuck16), .o_level(level16), .o_led(led16)
    );

    pwm_capture #(.CNT_WIDTH(8)) dut8 (
        .i_clk(clk), .i_reset_n(rst_n), .i_pwm(pwm),
        .o_high(high8), .o_period(period8), .o_valid(valid8),
        .o_stuck(stuck8), .o_level(level8), .o_led(led8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         hi;
        int         per;
        logic [3:0] led;
        int         at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    bit         armed = 1'b0;
    int         prev_hi, prev_per;
    logic [3:0] prev_led;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A rise closes the previous period; its capture appears 3 edges later.
    task automatic start_period(input int hi, input int per, input logic [3:0] led);
        exp_t e;
        if (armed) begin
            e.hi = prev_hi; e.per = prev_per; e.led = prev_led; e.at = cyc + 3;
            q.push_back(e);
        end
        armed = 1'b1;
        prev_hi = hi; prev_per = per; prev_led = led;
        pwm = 1'b1;
    endtask

    task automatic run_period(input int hi, input int per, input logic [3:0] led);
        start_period(hi, per, led);
        repeat (hi) step();
        pwm = 1'b0;
        repeat (per - hi) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pwm = ~pwm;
            step();
        end
        chk("rst_high", high16, 0);
        chk("rst_period", period16, 0);
        chk("rst_valid", valid16, 0);
        chk("rst_stuck", stuck16, 0);
        chk("rst_level", level16, 0);
        chk("rst_led", led16, 0);
        chk("rst_led8", led8, 0);
        pwm = 1'b0;
        rst_n = 1'b1;
        armed = 1'b0;
        repeat (3) step();
    endtask

    always @(negedge clk) begin
        if (rst_n && valid16) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got high=%0d period=%0d at cycle %0d, required none",
                         high16, period16, cyc);
            end else begin
                mon_e = q.pop_front();
                checks++;
                if (high16 !== mon_e.hi[15:0] || period16 !== mon_e.per[15:0] ||
                    led16 !== mon_e.led || cyc != mon_e.at) begin
                    errors++;
                    $display("FAIL capture: got high=%0d period=%0d led=%b cycle=%0d, required high=%0d period=%0d led=%b cycle=%0d",
                             high16, period16, led16, cyc, mon_e.hi, mon_e.per, mon_e.led, mon_e.at);
                end
            end
        end else if (q.size() > 0 && q[0].at < cyc) begin
            mon_e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_valid: got no strobe, required high=%0d period=%0d at cycle %0d",
                     mon_e.hi, mon_e.per, mon_e.at);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog");
    end

    int r;

    initial begin
        // Reset with toggling input, then a 25/100 waveform; first rise only arms.
        do_reset();
        repeat (4) run_period(25, 100, 4'b0001);

        // Duty sweep at period 100.
        run_period(12, 100, 4'b0000);
        run_period(50, 100, 4'b0011);
        run_period(62, 100, 4'b0011);
        run_period(63, 100, 4'b0111);
        run_period(99, 100, 4'b1111);

        // Minimum period: high 1, period 2.
        repeat (6) run_period(1, 2, 4'b0011);
        run_period(25, 100, 4'b0001);

        // Reset in the middle of a high phase drops the open period.
        do_reset();
        run_period(25, 100, 4'b0001);
        run_period(40, 100, 4'b0011);
        start_period(25, 100, 4'b0001);
        repeat (12) step();
        do_reset();
        run_period(30, 80, 4'b0011);
        run_period(30, 80, 4'b0011);
        run_period(30, 80, 4'b0011);

        // Timeout on the 8-bit instance: hold high after a valid period.
        do_reset();
        run_period(25, 100, 4'b0001);
        run_period(25, 100, 4'b0001);
        start_period(300, 320, 4'b1111);
        r = cyc;
        repeat (3) step();
        chk("t8_valid", valid8, 1);
        chk("t8_period", period8, 100);
        repeat (254) step();
        chk("t8_stuck_early", stuck8, 0);
        step();
        chk("t8_stuck_set", stuck8, 1);
        chk("t8_stuck_led", led8, 4'b1111);
        chk("t8_keep_high", high8, 25);
        chk("t8_keep_period", period8, 100);
        chk("t8_no_valid", valid8, 0);
        repeat (300 - 258) step();
        pwm = 1'b0;
        repeat (20) step();
        chk("t8_low_led", led8, 4'b0000);

        // Resume: stuck clears on the arming rise, capture on the next one.
        start_period(25, 100, 4'b0001);
        r = cyc;
        repeat (2) step();
        chk("t8_stuck_hold", stuck8, 1);
        step();
        chk("t8_stuck_clear", stuck8, 0);
        chk("t8_arm_no_valid", valid8, 0);
        repeat (22) step();
        pwm = 1'b0;
        repeat (75) step();
        start_period(25, 100, 4'b0001);
        repeat (3) step();
        chk("t8_resume_valid", valid8, 1);
        chk("t8_resume_high", high8, 25);
        chk("t8_resume_period", period8, 100);
        chk("t16_no_stuck", stuck16, 0);

        repeat (10) step();
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
